// File: rtl/jtframe_ba_pkg.sv
// Shared types and helpers for the four-bank SDRAM responder.
package jtframe_ba_pkg;

  localparam int NBANK = 4;

  typedef logic [1:0] bank_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } state_t;

  // One-hot strobe vector for a bank index.
  function automatic logic [NBANK-1:0] bank_onehot(input bank_t b);
    return {{(NBANK-1){1'b0}}, 1'b1} << b;
  endfunction

endpackage

// File: rtl/jtframe_ba_rr.sv
// Four-way round-robin picker: first requesting bank after `last`, wrapping 3->0.
module jtframe_ba_rr
  import jtframe_ba_pkg::*;
(
  input  logic [NBANK-1:0] req,
  input  bank_t            last,
  output bank_t            winner,
  output logic             valid
);

  bank_t idx_s;

  // Scan banks last+1 .. last+4 and keep the first one that is requesting.
  always_comb begin
    winner = 2'd0;
    valid  = 1'b0;
    idx_s  = last;
    for (int k = 1; k <= NBANK; k++) begin
      idx_s = last + bank_t'(k);
      if (!valid && req[idx_s]) begin
        winner = idx_s;
        valid  = 1'b1;
      end else begin
        valid  = valid;
      end
    end
  end

endmodule

// File: rtl/jtframe_ba_responder.sv
// Responder for the four-bank request interface: arbitrates bank requests
// round-robin, forwards one at a time to a burst memory port and returns
// the per-bank ack/dst/dok/rdy strobes with shared read data.
module jtframe_ba_responder
  import jtframe_ba_pkg::*;
#(
  parameter int AW    = 22,
  parameter int BURST = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AW-1:0]     ba0_addr,
  input  logic [AW-1:0]     ba1_addr,
  input  logic [AW-1:0]     ba2_addr,
  input  logic [AW-1:0]     ba3_addr,
  input  logic [NBANK-1:0]  ba_rd,
  input  logic              ba_wr,
  input  logic [15:0]       ba0_din,
  input  logic [1:0]        ba0_din_m,
  output logic [NBANK-1:0]  ba_ack,
  output logic [NBANK-1:0]  ba_dst,
  output logic [NBANK-1:0]  ba_dok,
  output logic [NBANK-1:0]  ba_rdy,
  output logic [15:0]       data_read,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [15:0]       mem_din,
  output logic [1:0]        mem_dsn,
  input  logic              mem_gnt,
  input  logic              mem_dvalid,
  input  logic [15:0]       mem_dout
);

  localparam int            CW        = $clog2(BURST) + 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(BURST - 1);

  state_t             state_r;
  bank_t              bank_r;
  bank_t              last_r;
  logic               we_r;
  logic [CW-1:0]      cnt_r;
  logic               mem_req_r;
  logic               mem_we_r;
  logic [AW-1:0]      mem_addr_r;
  logic [15:0]        mem_din_r;
  logic [1:0]         mem_dsn_r;
  logic [15:0]        data_read_r;
  logic [NBANK-1:0]   ba_ack_r;
  logic [NBANK-1:0]   ba_dst_r;
  logic [NBANK-1:0]   ba_dok_r;
  logic [NBANK-1:0]   ba_rdy_r;

  bank_t              winner_s;
  logic               valid_s;
  logic [AW-1:0]      pick_addr_s;

  jtframe_ba_rr u_rr (
    .req    (ba_rd),
    .last   (last_r),
    .winner (winner_s),
    .valid  (valid_s)
  );

  // Address of the bank the picker would grant this cycle.
  always_comb begin
    pick_addr_s = ba0_addr;
    case (winner_s)
      2'd0:    pick_addr_s = ba0_addr;
      2'd1:    pick_addr_s = ba1_addr;
      2'd2:    pick_addr_s = ba2_addr;
      2'd3:    pick_addr_s = ba3_addr;
      default: pick_addr_s = ba0_addr;
    endcase
  end

  // Request FSM with latched command and registered per-bank strobes.
  // The cycle carrying ba_rdy is not used for arbitration, so a bank that
  // keeps ba_rd high is only seen as a new request the cycle after.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      bank_r      <= 2'd0;
      last_r      <= 2'd3;
      we_r        <= 1'b0;
      cnt_r       <= {CW{1'b0}};
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {AW{1'b0}};
      mem_din_r   <= 16'h0000;
      mem_dsn_r   <= 2'b00;
      data_read_r <= 16'h0000;
      ba_ack_r    <= 4'b0000;
      ba_dst_r    <= 4'b0000;
      ba_dok_r    <= 4'b0000;
      ba_rdy_r    <= 4'b0000;
    end else begin
      ba_ack_r <= 4'b0000;
      ba_dst_r <= 4'b0000;
      ba_dok_r <= 4'b0000;
      ba_rdy_r <= 4'b0000;
      case (state_r)
        IDLE: begin
          if (valid_s && (ba_rdy_r == 4'b0000)) begin
            bank_r     <= winner_s;
            we_r       <= (winner_s == 2'd0) & ba_wr;
            mem_we_r   <= (winner_s == 2'd0) & ba_wr;
            mem_addr_r <= pick_addr_s;
            mem_din_r  <= ba0_din;
            mem_dsn_r  <= ba0_din_m;
            mem_req_r  <= 1'b1;
            state_r    <= REQ;
          end else begin
            state_r    <= IDLE;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req_r <= 1'b0;
            ba_ack_r  <= bank_onehot(bank_r);
            last_r    <= bank_r;
            cnt_r     <= {CW{1'b0}};
            if (we_r) begin
              ba_rdy_r <= bank_onehot(bank_r);
              state_r  <= IDLE;
            end else begin
              state_r  <= DATA;
            end
          end else begin
            state_r <= REQ;
          end
        end
        DATA: begin
          if (mem_dvalid) begin
            data_read_r <= mem_dout;
            ba_dok_r    <= bank_onehot(bank_r);
            cnt_r       <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
            if (cnt_r == {CW{1'b0}}) begin
              ba_dst_r <= bank_onehot(bank_r);
            end else begin
              ba_dst_r <= 4'b0000;
            end
            if (cnt_r == LAST_WORD) begin
              ba_rdy_r <= bank_onehot(bank_r);
              state_r  <= IDLE;
            end else begin
              state_r  <= DATA;
            end
          end else begin
            state_r <= DATA;
          end
        end
        default: begin
          state_r   <= IDLE;
          mem_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign ba_ack    = ba_ack_r;
  assign ba_dst    = ba_dst_r;
  assign ba_dok    = ba_dok_r;
  assign ba_rdy    = ba_rdy_r;
  assign data_read = data_read_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_din   = mem_din_r;
  assign mem_dsn   = mem_dsn_r;

endmodule

// File: tb/tb_jtframe_ba_responder.sv
// Scoreboard bench for jtframe_ba_responder (AW=22, BURST=2).
module tb_jtframe_ba_responder;

  localparam int AW    = 22;
  localparam int BURST = 2;

  logic            clk;
  logic            rst_n;
  logic [AW-1:0]   ba0_addr, ba1_addr, ba2_addr, ba3_addr;
  logic [3:0]      ba_rd;
  logic            ba_wr;
  logic [15:0]     ba0_din;
  logic [1:0]      ba0_din_m;
  logic [3:0]      ba_ack, ba_dst, ba_dok, ba_rdy;
  logic [15:0]     data_read;
  logic            mem_req, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [15:0]     mem_din;
  logic [1:0]      mem_dsn;
  logic            mem_gnt, mem_dvalid;
  logic [15:0]     mem_dout;

  jtframe_ba_responder #(.AW(AW), .BURST(BURST)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ba0_addr   (ba0_addr),
    .ba1_addr   (ba1_addr),
    .ba2_addr   (ba2_addr),
    .ba3_addr   (ba3_addr),
    .ba_rd      (ba_rd),
    .ba_wr      (ba_wr),
    .ba0_din    (ba0_din),
    .ba0_din_m  (ba0_din_m),
    .ba_ack     (ba_ack),
    .ba_dst     (ba_dst),
    .ba_dok     (ba_dok),
    .ba_rdy     (ba_rdy),
    .data_read  (data_read),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dsn    (mem_dsn),
    .mem_gnt    (mem_gnt),
    .mem_dvalid (mem_dvalid),
    .mem_dout   (mem_dout)
  );

  typedef struct {
    logic [3:0] ack;
    logic [3:0] rdy;
  } ack_exp_t;

  typedef struct {
    logic [3:0]  dok;
    logic [15:0] data;
    logic [3:0]  dst;
    logic [3:0]  rdy;
  } dok_exp_t;

  ack_exp_t ack_q[$];
  dok_exp_t dok_q[$];

  int n_pass;
  int n_total;
  int dok_seen;
  int rdy_seen;
  logic [AW-1:0] addr_tab [4];

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // Advance one cycle, sample #1 after the edge and retire scoreboard entries.
  task automatic tick();
    ack_exp_t ae;
    dok_exp_t de;
    @(posedge clk);
    #1;
    if (ba_dok != 4'b0000) dok_seen++;
    if (ba_rdy != 4'b0000) rdy_seen++;
    if (ba_ack != 4'b0000) begin
      n_total++;
      if (ack_q.size() == 0) begin
        $display("FAIL unexpected_ack: got ack=%b, required no ack", ba_ack);
      end else begin
        ae = ack_q.pop_front();
        if (ba_ack !== ae.ack || ba_rdy !== ae.rdy || ba_dok !== 4'b0000)
          $display("FAIL ack_strobe: got ack=%b rdy=%b dok=%b, required ack=%b rdy=%b dok=0000",
                   ba_ack, ba_rdy, ba_dok, ae.ack, ae.rdy);
        else n_pass++;
      end
    end
    if (ba_dok != 4'b0000) begin
      n_total++;
      if (dok_q.size() == 0) begin
        $display("FAIL unexpected_dok: got dok=%b data=%h, required no dok", ba_dok, data_read);
      end else begin
        de = dok_q.pop_front();
        if (ba_dok !== de.dok || data_read !== de.data || ba_dst !== de.dst || ba_rdy !== de.rdy)
          $display("FAIL read_word: got dok=%b data=%h dst=%b rdy=%b, required dok=%b data=%h dst=%b rdy=%b",
                   ba_dok, data_read, ba_dst, ba_rdy, de.dok, de.data, de.dst, de.rdy);
        else n_pass++;
      end
    end
    if (ba_ack == 4'b0000 && ba_dok == 4'b0000 && (ba_rdy != 4'b0000 || ba_dst != 4'b0000)) begin
      n_total++;
      $display("FAIL stray_strobe: got rdy=%b dst=%b, required 0000", ba_rdy, ba_dst);
    end
  endtask

  // Wait (bounded) for mem_req to rise.
  task automatic wait_req(input string name);
    int n;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    n_total++;
    if (mem_req !== 1'b1) $display("FAIL %s_req_timeout: got mem_req=%b, required 1", name, mem_req);
    else n_pass++;
  endtask

  // Grant after gdelay cycles and return a two-word burst for bank b.
  task automatic serve_read(input logic [1:0] b, input int gdelay,
                            input logic [15:0] w0, input logic [15:0] w1, input bit drop_rd);
    logic [3:0] oh;
    oh = 4'b0001 << b;
    ack_q.push_back('{ack: oh, rdy: 4'b0000});
    dok_q.push_back('{dok: oh, data: w0, dst: oh, rdy: 4'b0000});
    dok_q.push_back('{dok: oh, data: w1, dst: 4'b0000, rdy: oh});
    repeat (gdelay) tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    if (drop_rd) ba_rd[b] = 1'b0;
    n_total++;
    if (ba_ack !== oh || mem_req !== 1'b0)
      $display("FAIL ack_latency: got ack=%b mem_req=%b, required ack=%b mem_req=0", ba_ack, mem_req, oh);
    else n_pass++;
    tick();
    mem_dvalid = 1'b1;
    mem_dout   = w0;
    tick();
    mem_dout   = w1;
    tick();
    mem_dvalid = 1'b0;
  endtask

  task automatic check_queues_empty(input string name);
    n_total++;
    if (ack_q.size() != 0 || dok_q.size() != 0)
      $display("FAIL %s_pending: got %0d acks %0d words outstanding, required 0 and 0",
               name, ack_q.size(), dok_q.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    n_total++;
    if ({ba_ack, ba_dst, ba_dok, ba_rdy} !== 16'h0000)
      $display("FAIL reset_strobes: got %h, required 0000", {ba_ack, ba_dst, ba_dok, ba_rdy});
    else n_pass++;
    n_total++;
    if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 22'h0 || mem_din !== 16'h0 || mem_dsn !== 2'b00)
      $display("FAIL reset_mem: got req=%b we=%b addr=%h din=%h dsn=%b, required all 0",
               mem_req, mem_we, mem_addr, mem_din, mem_dsn);
    else n_pass++;
    n_total++;
    if (data_read !== 16'h0000) $display("FAIL reset_data: got %h, required 0000", data_read);
    else n_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    int d0;
    ba2_addr = 22'h12345;
    ba_rd    = 4'b0100;
    tick();
    n_total++;
    if (mem_req !== 1'b1 || mem_addr !== 22'h12345 || mem_we !== 1'b0)
      $display("FAIL read_cmd: got req=%b addr=%h we=%b, required req=1 addr=012345 we=0",
               mem_req, mem_addr, mem_we);
    else n_pass++;
    d0 = dok_seen;
    serve_read(2'd2, 3, 16'hAAAA, 16'hBBBB, 1'b1);
    tick();
    tick();
    n_total++;
    if (dok_seen - d0 !== 2) $display("FAIL read_dok_cycles: got %0d, required 2", dok_seen - d0);
    else n_pass++;
    check_queues_empty("single_read");
  endtask

  task automatic test_spurious();
    mem_dout   = 16'hDEAD;
    mem_dvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (data_read !== 16'hBBBB || ba_dok !== 4'b0000)
        $display("FAIL spurious_data: got data=%h dok=%b, required data=bbbb dok=0000", data_read, ba_dok);
      else n_pass++;
    end
    mem_dvalid = 1'b0;
  endtask

  task automatic test_write();
    int d0, r0;
    ba0_addr  = 22'h0ABCD;
    ba_wr     = 1'b1;
    ba0_din   = 16'h55AA;
    ba0_din_m = 2'b10;
    ba_rd     = 4'b0001;
    wait_req("write");
    n_total++;
    if (mem_we !== 1'b1 || mem_din !== 16'h55AA || mem_dsn !== 2'b10 || mem_addr !== 22'h0ABCD)
      $display("FAIL write_cmd: got we=%b din=%h dsn=%b addr=%h, required we=1 din=55aa dsn=10 addr=00abcd",
               mem_we, mem_din, mem_dsn, mem_addr);
    else n_pass++;
    ack_q.push_back('{ack: 4'b0001, rdy: 4'b0001});
    d0 = dok_seen;
    r0 = rdy_seen;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    ba_rd   = 4'b0000;
    ba_wr   = 1'b0;
    repeat (3) tick();
    n_total++;
    if (dok_seen !== d0 || rdy_seen - r0 !== 1)
      $display("FAIL write_strobes: got dok cycles=%0d rdy cycles=%0d, required 0 and 1",
               dok_seen - d0, rdy_seen - r0);
    else n_pass++;
    check_queues_empty("write");
  endtask

  task automatic test_stall();
    ba1_addr = 22'h3F00F;
    ba0_din  = 16'h1234;
    ba_rd    = 4'b0010;
    wait_req("stall");
    ba1_addr = 22'h00001;
    ba0_din  = 16'hFFFF;
    for (int i = 0; i < 50; i++) begin
      tick();
      n_total++;
      if (mem_req !== 1'b1 || mem_addr !== 22'h3F00F || mem_din !== 16'h1234)
        $display("FAIL stall_hold: cycle %0d got req=%b addr=%h din=%h, required req=1 addr=3f00f din=1234",
                 i, mem_req, mem_addr, mem_din);
      else n_pass++;
    end
    serve_read(2'd1, 0, 16'h1111, 16'h2222, 1'b1);
    repeat (3) tick();
    check_queues_empty("stall");
  endtask

  task automatic test_fairness();
    int order [5];
    order = '{0, 1, 2, 3, 0};
    addr_tab[0] = 22'h00100;
    addr_tab[1] = 22'h01100;
    addr_tab[2] = 22'h02100;
    addr_tab[3] = 22'h03100;
    ba0_addr = addr_tab[0];
    ba1_addr = addr_tab[1];
    ba2_addr = addr_tab[2];
    ba3_addr = addr_tab[3];
    ba_wr = 1'b0;
    rst_n = 1'b0;
    ba_rd = 4'b1111;
    tick();
    tick();
    rst_n = 1'b1;
    wait_req("fair");
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (mem_addr !== addr_tab[order[i]])
        $display("FAIL fair_order: grant %0d got addr=%h, required %h (bank %0d)",
                 i, mem_addr, addr_tab[order[i]], order[i]);
      else n_pass++;
      serve_read(2'(order[i]), 1, 16'(16'hA000 + i), 16'(16'hB000 + i), 1'b0);
      if (i == 4) ba_rd = 4'b0000;
      tick();
      n_total++;
      if (mem_req !== 1'b0) $display("FAIL b2b_gap: got mem_req=%b one cycle after rdy, required 0", mem_req);
      else n_pass++;
      if (i < 4) begin
        tick();
        n_total++;
        if (mem_req !== 1'b1) $display("FAIL b2b_next: got mem_req=%b two cycles after rdy, required 1", mem_req);
        else n_pass++;
      end
    end
    repeat (4) tick();
    n_total++;
    if (mem_req !== 1'b0) $display("FAIL fair_quiet: got mem_req=%b, required 0", mem_req);
    else n_pass++;
    check_queues_empty("fairness");
  endtask

  task automatic test_reset_data();
    int r0;
    ba0_addr = 22'h00777;
    ba_wr    = 1'b0;
    ba_rd    = 4'b0001;
    wait_req("rstdata");
    ack_q.push_back('{ack: 4'b0001, rdy: 4'b0000});
    dok_q.push_back('{dok: 4'b0001, data: 16'hCAFE, dst: 4'b0001, rdy: 4'b0000});
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    ba_rd   = 4'b0000;
    tick();
    mem_dvalid = 1'b1;
    mem_dout   = 16'hCAFE;
    tick();
    mem_dvalid = 1'b0;
    rst_n = 1'b0;
    tick();
    n_total++;
    if ({ba_ack, ba_dst, ba_dok, ba_rdy} !== 16'h0000 || data_read !== 16'h0000 ||
        mem_req !== 1'b0 || mem_addr !== 22'h0 || mem_din !== 16'h0 || mem_dsn !== 2'b00 || mem_we !== 1'b0)
      $display("FAIL rstdata_outputs: got strobes=%h data=%h req=%b addr=%h, required all 0",
               {ba_ack, ba_dst, ba_dok, ba_rdy}, data_read, mem_req, mem_addr);
    else n_pass++;
    rst_n = 1'b1;
    r0 = rdy_seen;
    mem_dvalid = 1'b1;
    mem_dout   = 16'hBEEF;
    tick();
    mem_dvalid = 1'b0;
    repeat (3) tick();
    n_total++;
    if (rdy_seen !== r0 || data_read !== 16'h0000)
      $display("FAIL rstdata_late: got rdy cycles=%0d data=%h, required 0 and 0000", rdy_seen - r0, data_read);
    else n_pass++;
    check_queues_empty("reset_data");
  endtask

  // Test sequence.
  initial begin
    n_pass = 0; n_total = 0; dok_seen = 0; rdy_seen = 0;
    rst_n = 1'b0;
    ba0_addr = 22'h0; ba1_addr = 22'h0; ba2_addr = 22'h0; ba3_addr = 22'h0;
    ba_rd = 4'b0000; ba_wr = 1'b0; ba0_din = 16'h0000; ba0_din_m = 2'b00;
    mem_gnt = 1'b0; mem_dvalid = 1'b0; mem_dout = 16'h0000;
    test_reset();
    test_single_read();
    test_spurious();
    test_write();
    test_stall();
    test_fairness();
    test_reset_data();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
